// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS LSB-first, optional parity, 1/2 stop bits, 3-sample vote, break detect.
// Latency: o_RX_DV at count M+1 of the last stop bit, about 4+(frame_bits-1)*CLKS_PER_BIT+M cycles after the start edge.
// Backpressure: none; o_RX_Byte is overwritten on every o_RX_DV.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam int M  = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CW-1:0] SAMP_A   = CW'(M - 1);
    localparam logic [CW-1:0] SAMP_B   = CW'(M);
    localparam logic [CW-1:0] SAMP_C   = CW'(M + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rx_s;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [IW-1:0]        idx;
    logic                 stop_idx;
    logic                 samp_a, samp_b;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 ferr_acc;

    logic vote, at_vote, at_end, done;
    logic ferr_now, brk_now, perr_now;

    assign at_vote = (cnt == SAMP_C);
    assign at_end  = (cnt == CNT_LAST);
    assign vote    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

    // Frame verdicts are only consumed at the vote point of the last stop bit.
    assign ferr_now = ferr_acc | ~vote;
    assign brk_now  = (shift == '0) && ((PARITY_MODE == 0) || !par_bit) && ferr_now;
    always_comb begin
        perr_now = 1'b0;
        if (PARITY_MODE == 1)
            perr_now = ~(^shift ^ par_bit);
        else if (PARITY_MODE == 2)
            perr_now = ^shift ^ par_bit;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = at_end ? '0 : cnt + 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = CW'(1);
                end
            end
            START: begin
                if (at_vote && vote) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (at_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (at_end && idx == IDX_LAST)
                    state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
            end
            PARITY: begin
                if (at_end)
                    state_nxt = STOP;
            end
            STOP: begin
                // Finish mid-bit so a back-to-back start edge is not missed.
                if (at_vote && stop_idx == STOP_LAST) begin
                    done      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = brk_now ? BRK_WAIT : IDLE;
                end
            end
            BRK_WAIT: begin
                cnt_nxt = '0;
                if (rx_s)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            stop_idx     <= 1'b0;
            samp_a       <= 1'b1;
            samp_b       <= 1'b1;
            shift        <= '0;
            par_bit      <= 1'b0;
            ferr_acc     <= 1'b0;
            o_RX_DV      <= 1'b0;
            o_RX_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_s    <= rx_meta;
            state   <= state_nxt;
            cnt     <= cnt_nxt;

            if (cnt == SAMP_A) samp_a <= rx_s;
            if (cnt == SAMP_B) samp_b <= rx_s;

            if (state == START) begin
                idx      <= '0;
                stop_idx <= 1'b0;
                ferr_acc <= 1'b0;
            end
            if (state == DATA && at_vote) shift[idx] <= vote;
            if (state == DATA && at_end)  idx <= idx + 1'b1;
            if (state == PARITY && at_vote) par_bit <= vote;
            if (state == STOP && at_vote) ferr_acc <= ferr_now;
            if (state == STOP && at_end)  stop_idx <= 1'b1;

            o_RX_DV <= done;
            if (done) begin
                o_RX_Byte    <= brk_now ? '0 : shift;
                o_Parity_Err <= perr_now;
                o_Frame_Err  <= ferr_now;
                o_Break      <= brk_now;
            end else begin
                o_Parity_Err <= 1'b0;
                o_Frame_Err  <= 1'b0;
                o_Break      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: six receiver configurations fed from bit-level serial frames, scored against a frame model.
module tb_uart_rx_cfg;
    localparam int CPB = 16;
    localparam int M   = (CPB - 1) / 2;
    localparam int NI  = 6;
    // Per-instance configuration: data bits, parity mode, stop bits.
    localparam int ND [NI] = '{8, 8, 8, 7, 9, 8};
    localparam int PM [NI] = '{0, 2, 0, 0, 0, 1};
    localparam int NS [NI] = '{1, 1, 2, 1, 1, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [NI-1:0] line;
    logic [NI-1:0] dv, pe, fe, bk;
    logic [7:0]    byte_a, byte_b, byte_c, byte_f;
    logic [6:0]    byte_d;
    logic [8:0]    byte_e;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(line[0]), .o_RX_DV(dv[0]), .o_RX_Byte(byte_a),
        .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_Break(bk[0]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_b (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(line[1]), .o_RX_DV(dv[1]), .o_RX_Byte(byte_b),
        .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_Break(bk[1]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_c (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(line[2]), .o_RX_DV(dv[2]), .o_RX_Byte(byte_c),
        .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]), .o_Break(bk[2]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(1)) u_d (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(line[3]), .o_RX_DV(dv[3]), .o_RX_Byte(byte_d),
        .o_Parity_Err(pe[3]), .o_Frame_Err(fe[3]), .o_Break(bk[3]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY_MODE(0), .STOP_BITS(1)) u_e (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(line[4]), .o_RX_DV(dv[4]), .o_RX_Byte(byte_e),
        .o_Parity_Err(pe[4]), .o_Frame_Err(fe[4]), .o_Break(bk[4]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) u_f (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(line[5]), .o_RX_DV(dv[5]), .o_RX_Byte(byte_f),
        .o_Parity_Err(pe[5]), .o_Frame_Err(fe[5]), .o_Break(bk[5]));

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       pe, fe, bk;
        int         t;
    } rec_t;

    rec_t capq[$];
    int   cyc = 0;
    int   flag_viol = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every DV pulse; flags outside a DV pulse are counted as violations.
    always @(negedge clk) begin
        logic [8:0] bv [NI];
        rec_t r;
        bv[0] = {1'b0, byte_a};
        bv[1] = {1'b0, byte_b};
        bv[2] = {1'b0, byte_c};
        bv[3] = {2'b0, byte_d};
        bv[4] = byte_e;
        bv[5] = {1'b0, byte_f};
        for (int i = 0; i < NI; i++) begin
            if (dv[i] === 1'b1) begin
                r.inst = i; r.data = bv[i]; r.pe = pe[i]; r.fe = fe[i]; r.bk = bk[i]; r.t = cyc;
                capq.push_back(r);
            end else if ((pe[i] | fe[i] | bk[i]) !== 1'b0) begin
                flag_viol++;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int inst, input logic v, input int n);
        line[inst] = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drive one frame; gbit >= 0 inverts that data bit for one cycle at offset M.
    task automatic send(input int inst, input logic [8:0] data, input logic pbit,
                        input logic [1:0] stops, input int gbit, output int t0);
        t0 = cyc;
        hold(inst, 1'b0, CPB);
        for (int i = 0; i < ND[inst]; i++) begin
            if (i == gbit) begin
                hold(inst, data[i], M);
                hold(inst, ~data[i], 1);
                hold(inst, data[i], CPB - M - 1);
            end else begin
                hold(inst, data[i], CPB);
            end
        end
        if (PM[inst] != 0) hold(inst, pbit, CPB);
        for (int i = 0; i < NS[inst]; i++) hold(inst, stops[i], CPB);
        line[inst] = 1'b1;
    endtask

    task automatic expect_rec(input string tag, input int inst, input logic [8:0] eb,
                              input logic epe, input logic efe, input logic ebk, input int elat);
        rec_t r;
        int   lat;
        chk({tag, "_dv_present"}, int'(capq.size() > 0), 1);
        if (capq.size() > 0) begin
            r = capq.pop_front();
            lat = r.t;
            chk({tag, "_inst"}, r.inst, inst);
            chk({tag, "_byte"}, int'(r.data), int'(eb));
            chk({tag, "_parity_err"}, int'(r.pe), int'(epe));
            chk({tag, "_frame_err"}, int'(r.fe), int'(efe));
            chk({tag, "_break"}, int'(r.bk), int'(ebk));
            n_assert++;
            assert (lat >= elat - 1 && lat <= elat + 1) else begin
                n_fail++;
                $error("FAIL %s_latency: observed %0d expected %0d +/-1", tag, lat, elat);
            end
        end
    endtask

    // Frame model: expected outputs computed from what was put on the wire.
    task automatic expect_frame(input string tag, input int inst, input logic [8:0] data,
                                input logic pbit, input logic [1:0] stops, input int t0);
        logic [8:0] mask, d;
        logic       x, epe, efe, ebk;
        int         nbits;
        mask = 9'((1 << ND[inst]) - 1);
        d    = data & mask;
        x    = ^d ^ pbit;
        epe  = (PM[inst] == 1) ? ~x : (PM[inst] == 2) ? x : 1'b0;
        efe  = !stops[0] || (NS[inst] == 2 && !stops[1]);
        ebk  = (d == 0) && (PM[inst] == 0 || !pbit) && efe;
        nbits = 1 + ND[inst] + ((PM[inst] != 0) ? 1 : 0) + NS[inst];
        expect_rec(tag, inst, ebk ? 9'd0 : d, epe, efe, ebk, t0 + 4 + (nbits - 1) * CPB + M);
    endtask

    initial begin
        int t0, t1;
        logic [8:0] rd;
        logic       rp;
        logic [1:0] rs;

        rst  = 1'b1;
        line = '1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("reset_dv", int'(dv), 0);
        chk("reset_byte_a", int'(byte_a), 0);
        chk("reset_byte_e", int'(byte_e), 0);
        chk("reset_flags", int'(pe | fe | bk), 0);

        // Back-to-back 8N1 frames.
        send(0, 9'h0A5, 1'b0, 2'b11, -1, t0);
        send(0, 9'h03C, 1'b0, 2'b11, -1, t1);
        hold(0, 1'b1, 2 * CPB);
        expect_frame("b2b_first", 0, 9'h0A5, 1'b0, 2'b11, t0);
        expect_frame("b2b_second", 0, 9'h03C, 1'b0, 2'b11, t1);
        chk("b2b_no_extra", capq.size(), 0);

        // Even parity, correct then wrong parity bit.
        send(1, 9'h007, 1'b1, 2'b11, -1, t0);
        hold(1, 1'b1, 2 * CPB);
        expect_frame("even_ok", 1, 9'h007, 1'b1, 2'b11, t0);
        send(1, 9'h007, 1'b0, 2'b11, -1, t0);
        hold(1, 1'b1, 2 * CPB);
        expect_rec("even_bad", 1, 9'h007, 1'b1, 1'b0, 1'b0, t0 + 4 + 10 * CPB + M);

        // Start-bit glitch rejected, then a mid-bit glitch outvoted.
        hold(0, 1'b0, 3);
        hold(0, 1'b1, 2 * CPB);
        chk("glitch_no_dv", capq.size(), 0);
        send(0, 9'h000, 1'b0, 2'b11, 2, t0);
        hold(0, 1'b1, 2 * CPB);
        expect_rec("vote_fix", 0, 9'h000, 1'b0, 1'b0, 1'b0, t0 + 4 + 9 * CPB + M);

        // Two stop bits, second one low.
        send(2, 9'h055, 1'b0, 2'b01, -1, t0);
        hold(2, 1'b1, 2 * CPB);
        expect_rec("stop2_bad", 2, 9'h055, 1'b0, 1'b1, 1'b0, t0 + 4 + 10 * CPB + M);
        chk("stop2_no_extra", capq.size(), 0);

        // Line held low: one break report, then normal traffic resumes.
        t0 = cyc;
        hold(0, 1'b0, 20 * CPB);
        hold(0, 1'b1, CPB);
        expect_rec("break", 0, 9'h000, 1'b0, 1'b1, 1'b1, t0 + 4 + 9 * CPB + M);
        chk("break_single_dv", capq.size(), 0);
        send(0, 9'h081, 1'b0, 2'b11, -1, t0);
        hold(0, 1'b1, 2 * CPB);
        expect_rec("after_break", 0, 9'h081, 1'b0, 1'b0, 1'b0, t0 + 4 + 9 * CPB + M);

        // Reset during data bit 4 of 0xF0 drops the frame.
        hold(0, 1'b0, CPB);
        hold(0, 1'b0, 4 * CPB);
        hold(0, 1'b1, M);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset_byte", int'(byte_a), 0);
        hold(0, 1'b1, 6 * CPB);
        chk("midreset_no_dv", capq.size(), 0);
        send(0, 9'h042, 1'b0, 2'b11, -1, t0);
        hold(0, 1'b1, 2 * CPB);
        expect_frame("post_reset", 0, 9'h042, 1'b0, 2'b11, t0);

        // Narrow and wide data widths.
        send(3, 9'h05A, 1'b0, 2'b11, -1, t0);
        hold(3, 1'b1, 2 * CPB);
        expect_rec("d7", 3, 9'h05A, 1'b0, 1'b0, 1'b0, t0 + 4 + 8 * CPB + M);
        send(4, 9'h1A5, 1'b0, 2'b11, -1, t0);
        hold(4, 1'b1, 2 * CPB);
        expect_rec("d9", 4, 9'h1A5, 1'b0, 1'b0, 1'b0, t0 + 4 + 10 * CPB + M);

        // Random frames on every configuration, occasionally with bad stop bits.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NI; i++) begin
                rd = 9'($urandom_range(0, 511));
                if ($urandom_range(0, 7) == 0) rd = 9'd0;
                rp = 1'($urandom_range(0, 1));
                rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
                send(i, rd, rp, rs, -1, t0);
                hold(i, 1'b1, 2 * CPB);
                expect_frame("random", i, rd, rp, rs, t0);
                chk("random_no_extra", capq.size(), 0);
            end
        end

        chk("flags_quiet_without_dv", flag_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
